// File: rtl/rsa_pkg.sv
// Shared widths, FSM encoding and mode codes for the RSA word sequencer.
package rsa_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    COLLECT,
    LAUNCH,
    WAIT,
    SEND
  } state_t;
endpackage

// File: rtl/rsa_byte_serializer.sv
// Loads a 32-bit word and emits it MSB-first as four valid/ready bytes.
module rsa_byte_serializer
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              word_sent
);
  logic [WORD_W-1:0] r_data;
  logic [1:0]        r_idx;
  logic              r_valid;
  logic              r_last;
  logic              w_final_byte;

  assign w_final_byte = (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (load && !r_valid) begin
      r_data  <= load_data;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_last  <= load_last;
    end else if (r_valid && out_ready) begin
      // Shift the next byte into the MSB position so out_data is a fixed slice.
      r_data <= {r_data[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      r_idx  <= r_idx + 2'd1;
      if (w_final_byte) r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data[WORD_W-1 -: BYTE_W];
  assign out_valid = r_valid;
  assign out_last  = r_valid && r_last && w_final_byte;
  assign word_sent = r_valid && out_ready && w_final_byte;
endmodule

// File: rtl/rsa_word_sequencer.sv
// Packs bytes into words, launches one modular exponentiation per word and
// serializes each result back out as bytes.
module rsa_word_sequencer
  import rsa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [WORD_W-1:0] key_e,
  input  logic [WORD_W-1:0] key_d,
  input  logic [WORD_W-1:0] key_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              fme_start,
  output logic [WORD_W-1:0] fme_base,
  output logic [WORD_W-1:0] fme_exponent,
  output logic [WORD_W-1:0] fme_modulo,
  input  logic [WORD_W-1:0] fme_result,
  input  logic              fme_done,
  output logic              err_mod,
  output logic              busy,
  output logic [CNT_W-1:0]  words_done
);
  state_t            r_state, w_state_next;
  logic [1:0]        r_byte_cnt;
  logic [WORD_W-1:0] r_word, r_exp, r_mod;
  logic              r_last_flag;
  logic [CNT_W-1:0]  r_words_done;

  logic              w_in_ready, w_fme_start, w_err_mod, w_ser_load;
  logic              w_accept, w_word_sent, w_ser_valid, w_ser_last;
  logic [WORD_W-1:0] w_word_base, w_word_merged;

  // Starting a fresh word clears the shift register, so a short word ends zero-padded.
  assign w_word_base   = (r_byte_cnt == 2'd0) ? '0 : r_word;
  assign w_word_merged = w_word_base |
                         ({in_data, {(WORD_W-BYTE_W){1'b0}}} >> {r_byte_cnt, 3'b000});
  assign w_accept      = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_fme_start  = 1'b0;
    w_err_mod    = 1'b0;
    w_ser_load   = 1'b0;
    case (r_state)
      COLLECT: begin
        w_in_ready = 1'b1;
        if (in_valid && (in_last || r_byte_cnt == 2'(BYTES_PER_WORD - 1)))
          w_state_next = LAUNCH;
      end
      LAUNCH: begin
        if (r_mod < WORD_W'(2)) begin
          w_err_mod    = 1'b1;
          w_state_next = COLLECT;
        end else begin
          w_fme_start  = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (fme_done) begin
          w_ser_load   = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (w_word_sent) w_state_next = COLLECT;
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_exp        <= '0;
      r_mod        <= '0;
      r_last_flag  <= 1'b0;
      r_words_done <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_word     <= w_word_merged;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      // Keys are captured on the edge into LAUNCH so they are valid alongside fme_start.
      if (r_state == COLLECT && w_state_next == LAUNCH) begin
        r_exp       <= (mode == MODE_DEC) ? key_d : key_e;
        r_mod       <= key_n;
        r_last_flag <= in_last;
      end
      if (r_state != COLLECT && w_state_next == COLLECT) r_byte_cnt <= '0;
      if (w_word_sent) r_words_done <= r_words_done + CNT_W'(1);
    end
  end

  rsa_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (w_ser_load),
    .load_data (fme_result),
    .load_last (r_last_flag),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (w_ser_valid),
    .out_last  (w_ser_last),
    .word_sent (w_word_sent)
  );

  assign in_ready     = w_in_ready && !rst;
  assign fme_start    = w_fme_start && !rst;
  assign err_mod      = w_err_mod && !rst;
  assign out_valid    = w_ser_valid && !rst;
  assign out_last     = w_ser_last && !rst;
  assign busy         = !(r_state == COLLECT && r_byte_cnt == 2'd0) && !rst;
  assign fme_base     = r_word;
  assign fme_exponent = r_exp;
  assign fme_modulo   = r_mod;
  assign words_done   = r_words_done;
endmodule

// File: tb/tb_rsa_word_sequencer.sv
// Directed and randomized checks of the word sequencer against a byte/word
// reference model and a behavioural modular-exponentiation core.
module tb_rsa_word_sequencer;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [31:0] key_e, key_d, key_n;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready;
  logic        fme_start, fme_done;
  logic [31:0] fme_base, fme_exponent, fme_modulo, fme_result;
  logic        err_mod, busy;
  logic [CNT_W-1:0] words_done;

  int vectors     = 0;
  int miscompares = 0;

  rsa_word_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key_e(key_e), .key_d(key_d), .key_n(key_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .fme_start(fme_start), .fme_base(fme_base), .fme_exponent(fme_exponent),
    .fme_modulo(fme_modulo), .fme_result(fme_result), .fme_done(fme_done),
    .err_mod(err_mod), .busy(busy), .words_done(words_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r, bb;
    r  = 64'd1 % {32'd0, n};
    bb = {32'd0, b} % {32'd0, n};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * bb) % {32'd0, n};
      bb = (bb * bb) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  // Behavioural exponentiation core: answers each launch after a delay.
  int          core_delay_cfg = 0;
  int          core_cnt = -1;
  int          starts_seen = 0;
  logic [31:0] core_res;
  initial begin
    fme_done   = 1'b0;
    fme_result = '0;
  end
  always @(negedge clk) begin
    fme_done   = 1'b0;
    fme_result = $urandom;
    if (fme_start) begin
      starts_seen++;
      core_res = modexp(fme_base, fme_exponent, fme_modulo);
      core_cnt = (core_delay_cfg > 0) ? core_delay_cfg : int'($urandom_range(1, 6));
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        fme_done   = 1'b1;
        fme_result = core_res;
        core_cnt   = -1;
      end
    end
  end

  logic [CNT_W-1:0] exp_wd = '0;

  // One word through the sequencer; bytes come from bw MSB-first.
  task automatic run_word(input logic [31:0] bw, input int nb, input bit lst, input bit md,
                          input int stall_at, input bit tweak);
    logic [31:0] exp_base, exp_exp, exp_n, exp_res, prev_data, saved_e;
    logic [7:0]  exp_byte;
    int k, cyc, stalls, starts_before, gap;
    bit prev_stall, saw_out;
    exp_base = 0;
    for (int i = 0; i < nb; i++) exp_base = exp_base + ({24'd0, bw[31-8*i -: 8]} << (24 - 8*i));
    exp_exp = md ? key_d : key_e;
    exp_n   = key_n;
    saved_e = key_e;
    starts_before = starts_seen;
    mode = md;
    for (int i = 0; i < nb; i++) begin
      in_data  = bw[31-8*i -: 8];
      in_valid = 1'b1;
      in_last  = lst && (i == nb - 1);
      if (i == 0) chk("in_ready_collect", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      if (i < nb - 1) begin
        gap = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_launch", {63'd0, in_ready}, 64'd0);
    if (exp_n < 2) begin
      chk("err_mod_pulse", {63'd0, err_mod}, 64'd1);
      chk("no_start_on_err", {63'd0, fme_start}, 64'd0);
      @(negedge clk);
      chk("err_mod_one_cycle", {63'd0, err_mod}, 64'd0);
      saw_out = 1'b0;
      repeat (10) begin
        if (out_valid) saw_out = 1'b1;
        @(negedge clk);
      end
      chk("no_output_on_err", {63'd0, saw_out}, 64'd0);
      chk("starts_on_err", 64'(starts_seen), 64'(starts_before));
      chk("words_done_err", {48'd0, words_done}, {48'd0, exp_wd});
      chk("busy_after_err", {63'd0, busy}, 64'd0);
      return;
    end
    chk("fme_start", {63'd0, fme_start}, 64'd1);
    chk("fme_base", {32'd0, fme_base}, {32'd0, exp_base});
    chk("fme_exponent", {32'd0, fme_exponent}, {32'd0, exp_exp});
    chk("fme_modulo", {32'd0, fme_modulo}, {32'd0, exp_n});
    exp_res = modexp(exp_base, exp_exp, exp_n);
    if (tweak) begin
      @(negedge clk);
      mode  = ~mode;
      key_e = key_e ^ 32'h0000_5555;
      @(negedge clk);
      chk("exp_held", {32'd0, fme_exponent}, {32'd0, exp_exp});
      chk("mod_held", {32'd0, fme_modulo}, {32'd0, exp_n});
    end
    k = 0; cyc = 0; stalls = 0; prev_stall = 1'b0; prev_data = '0;
    while (k < 4 && cyc < 200) begin
      if (prev_stall) chk("stall_stable", {56'd0, out_data}, {56'd0, prev_data[7:0]});
      if (out_valid && k == stall_at && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready) begin
        exp_byte = exp_res[31-8*k -: 8];
        chk("out_byte", {56'd0, out_data}, {56'd0, exp_byte});
        chk("out_last", {63'd0, out_last}, {63'd0, (lst && k == 3)});
        $display("  out byte %0d = %02h", k, out_data);
        k++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = {24'd0, out_data};
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("out_timeout", 64'(k), 64'd4);
    exp_wd = exp_wd + CNT_W'(1);
    chk("words_done", {48'd0, words_done}, {48'd0, exp_wd});
    chk("out_valid_after", {63'd0, out_valid}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("start_count", 64'(starts_seen), 64'(starts_before + 1));
    key_e = saved_e;
    $display("word base=%08h exp=%08h n=%08h res=%08h last=%0d", exp_base, exp_exp, exp_n,
             exp_res, lst);
  endtask

  initial begin
    int nb, cyc;
    bit lst, saw_out;
    logic [31:0] bw;
    rst = 1'b1; mode = 1'b0; key_e = 32'd17; key_d = 32'd2753; key_n = 32'd3233;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fme_start", {63'd0, fme_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_words_done", {48'd0, words_done}, 64'd0);
    chk("rst_fme_base", {32'd0, fme_base}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_word(32'h0000_0041, 4, 1'b0, 1'b0, -1, 1'b0);
    run_word(32'h0000_0AE6, 4, 1'b0, 1'b1, -1, 1'b0);
    run_word(32'hAABB_0000, 2, 1'b1, 1'b0, -1, 1'b0);
    key_n = 32'd1;
    run_word(32'h1122_3344, 4, 1'b0, 1'b0, -1, 1'b0);
    key_n = 32'd3233;
    run_word(32'h0000_0101, 4, 1'b1, 1'b0, -1, 1'b0);
    run_word(32'h0000_0123, 4, 1'b0, 1'b0, 2, 1'b1);

    for (int w = 0; w < 10; w++) begin
      key_e = $urandom; key_d = $urandom;
      key_n = ($urandom_range(0, 7) == 0) ? 32'(w & 1) : ($urandom | 32'h2);
      nb  = $urandom_range(1, 4);
      lst = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      bw  = $urandom;
      run_word(bw, nb, lst, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    // Reset while the core is busy; its late done must be ignored.
    key_n = 32'd3233; key_e = 32'd17;
    core_delay_cfg = 8;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rst_test_start", {63'd0, fme_start}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_wd = '0;
    saw_out = 1'b0;
    cyc = 0;
    repeat (15) begin
      out_ready = 1'b1;
      if (out_valid) saw_out = 1'b1;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("rst_drop_output", {63'd0, saw_out}, 64'd0);
    chk("rst_drop_busy", {63'd0, busy}, 64'd0);
    chk("rst_drop_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_drop_words", {48'd0, words_done}, {48'd0, exp_wd});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
